mips_run_controller: RTL
========================

// Module: mips_run_controller
// PURPOSE
//  Synthesisable run sequencer for mod_mips_processor. Drives the core's reset, hold and dump_all.
//  Sequence: core reset -> run -> on mem_end, drain -> register/memory dump -> done.
//  Adds single-step mode, cycle and issue counters, and an optional watchdog.
//  Sits between the instruction ROM mem_end flag and the core/data-memory control pins.
// PARAMETERS
//  CNT_W         32   width of cycle_count / issue_count
//  RESET_CYCLES  2    cycles core_reset held high after start (>=1)
//  DRAIN_CYCLES  10   hold cycles between mem_end and dump_all (>=1)
//  DUMP_CYCLES   1    cycles dump_all held high (>=1)
//  WDOG_CYCLES   4096 issue-count limit before forced stop (used only with RUN_CTRL_WATCHDOG_EN)
// PORTS
//  clk          in   1      single clock, all logic on posedge
//  reset        in   1      synchronous, active-high
//  start        in   1      pulse: begin a run (honoured in IDLE and DONE only)
//  step_mode    in   1      1 = single-step; sampled on the start cycle, fixed for the run
//  step         in   1      pulse: release exactly one issue cycle in step mode
//  mem_end      in   1      instruction ROM end-of-program flag
//  core_reset   out  1      to core reset
//  hold         out  1      to core hold
//  dump_all     out  1      to core dump_all and data-memory dump
//  busy         out  1      high in RST, RUN, DRAIN and DUMP
//  done         out  1      high in DONE
//  timeout      out  1      sticky watchdog flag (constant 0 when the macro is off)
//  cycle_count  out  CNT_W  clocks spent in RUN, saturating
//  issue_count  out  CNT_W  RUN cycles with hold=0, saturating
// BEHAVIOUR
//  Reset: state=IDLE, core_reset=1, hold=1, dump_all=0, busy=0, done=0, timeout=0, counters=0.
//  All outputs are registered; each takes its new value on the edge that enters a state.
//  IDLE : core_reset=1, hold=1. start -> RST; latch step_mode; clear counters and timeout.
//  RST  : core_reset=1, hold=1 for exactly RESET_CYCLES cycles -> RUN.
//  RUN  : core_reset=0. Free mode: hold=0 every cycle.
//         Step mode: hold=0 only in the cycle after a step pulse; otherwise hold=1.
//         A step arriving while a release cycle is pending is dropped (no queueing).
//         cycle_count +1 per RUN cycle; issue_count +1 per RUN cycle with hold=0.
//         Both counters saturate at 2^CNT_W-1 with no wrap.
//         mem_end=1 sampled -> DRAIN; hold=1 from the next cycle.
//         If mem_end and step arrive in the same cycle, mem_end wins and the step is dropped.
//  DRAIN: hold=1 for DRAIN_CYCLES cycles, counters frozen -> DUMP.
//  DUMP : hold=1, dump_all=1 for DUMP_CYCLES cycles -> DONE; dump_all=0 from the DONE cycle.
//  DONE : done=1, hold=1, core_reset=0; counters and timeout held for readout.
//         start -> RST (clears counters and timeout).
//  start outside IDLE/DONE is ignored. mem_end outside RUN is ignored.
//  reset in any state returns to IDLE with reset values on the next edge.
//  A run aborted by reset produces no dump.
// CONFIGURATION
//  RUN_CTRL_WATCHDOG_EN defined:
//    In RUN, if issue_count reaches WDOG_CYCLES before mem_end, enter DRAIN with timeout=1.
//    timeout stays set through DUMP/DONE and clears on the next start or reset.
//    If the limit and mem_end coincide: enter DRAIN with timeout=1.
//    Counting on issue_count means a stalled step-mode run never times out.
//  RUN_CTRL_WATCHDOG_EN undefined:
//    No watchdog logic; timeout tied to 0; WDOG_CYCLES unused.
// TESTING
//  1. Reset 3 cycles, start, mem_end at RUN cycle 20 ->
//     core_reset high 2 cycles; hold=0 for 20 cycles; hold=1 for 10 cycles;
//     dump_all=1 for 1 cycle; done=1; cycle_count=20, issue_count=20.
//  2. step_mode=1, 5 step pulses 3 cycles apart, then mem_end ->
//     exactly 5 single-cycle hold=0 windows; issue_count=5, cycle_count=15.
//  3. mem_end and step in the same RUN cycle ->
//     no release cycle; DRAIN entered; issue_count unchanged.
//  4. Reset asserted in DRAIN cycle 4 ->
//     next edge: IDLE, core_reset=1, hold=1; dump_all never pulses; counters=0.
//  5. CNT_W=4, free run of 20 cycles -> cycle_count and issue_count saturate at 15.
//  6. RUN_CTRL_WATCHDOG_EN, WDOG_CYCLES=8, mem_end never asserted ->
//     DRAIN after issue_count=8; timeout=1 through DONE; next start clears it.
//     Without the macro: run continues, timeout=0.

Source files
------------

// File: rtl/mips_run_controller_if.sv
// mips_run_controller_if
//   Bundles the run controller's control and status signals.
//   master : host / sequencer side (drives start, step_mode, step, mem_end)
//   slave  : controller side (drives core controls, status flags and counters)
//   Parameter CNT_W sets the width of cycle_count / issue_count.
interface mips_run_controller_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             step_mode;
    logic             step;
    logic             mem_end;
    logic             core_reset;
    logic             hold;
    logic             dump_all;
    logic             busy;
    logic             done;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] issue_count;

    modport master (
        output start, step_mode, step, mem_end,
        input  core_reset, hold, dump_all, busy, done, timeout,
        input  cycle_count, issue_count
    );

    modport slave (
        input  start, step_mode, step, mem_end,
        output core_reset, hold, dump_all, busy, done, timeout,
        output cycle_count, issue_count
    );
endinterface

// File: rtl/mips_run_controller.sv
// mips_run_controller
//   Run sequencer for the MIPS core: core reset -> run -> drain -> dump -> done,
//   with single-step mode, saturating cycle/issue counters and an optional
//   issue-count watchdog (enabled by defining RUN_CTRL_WATCHDOG_EN).
// Ports
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : mips_run_controller_if.slave
//           in : start, step_mode, step, mem_end
//           out: core_reset, hold, dump_all, busy, done, timeout,
//                cycle_count, issue_count
// All outputs are registered and take their new value on the edge that
// enters the corresponding state.
//
// state  | meaning
// IDLE   | core held in reset, waiting for start
// RST    | core reset asserted for RESET_CYCLES
// RUN    | core executing (free or single-step), counters running
// DRAIN  | core held for DRAIN_CYCLES, counters frozen
// DUMP   | dump_all asserted for DUMP_CYCLES
// DONE   | run finished, counters/timeout held for readout
module mips_run_controller #(
    parameter int CNT_W        = 32,
    parameter int RESET_CYCLES = 2,
    parameter int DRAIN_CYCLES = 10,
    parameter int DUMP_CYCLES  = 1
`ifdef RUN_CTRL_WATCHDOG_EN
    ,
    parameter int WDOG_CYCLES  = 4096
`endif
) (
    input logic                  clk,
    input logic                  reset,
    mips_run_controller_if.slave bus
);

    localparam int TMR_MAX_RD = (RESET_CYCLES > DRAIN_CYCLES) ? RESET_CYCLES : DRAIN_CYCLES;
    localparam int TMR_MAX    = (TMR_MAX_RD > DUMP_CYCLES) ? TMR_MAX_RD : DUMP_CYCLES;
    // Down-counter only ever holds (cycles - 1).
    localparam int TMR_W      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0] TMR_RST   = TMR_W'(RESET_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_DRAIN = TMR_W'(DRAIN_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_DUMP  = TMR_W'(DUMP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

`ifdef RUN_CTRL_WATCHDOG_EN
    // A limit above the saturation value can never be reached.
    localparam bit               WDOG_REACHABLE = (CNT_W >= 31) ||
                                                  (WDOG_CYCLES <= ((1 << CNT_W) - 1));
    localparam logic [CNT_W-1:0] WDOG_LIM       = CNT_W'(WDOG_CYCLES);
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_DRAIN,
        S_DUMP,
        S_DONE
    } state_t;

    state_t           state, state_nxt;
    logic [TMR_W-1:0] tmr, tmr_nxt;
    logic [CNT_W-1:0] cyc_q, cyc_nxt;
    logic [CNT_W-1:0] iss_q, iss_nxt;
    logic             mode_q, mode_nxt;
    logic             hold_q, hold_nxt;
    logic             run_end;
    logic             core_reset_q;
    logic             dump_q;
    logic             busy_q;
    logic             done_q;
`ifdef RUN_CTRL_WATCHDOG_EN
    logic             to_q, to_nxt;
`endif

    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        cyc_nxt   = cyc_q;
        iss_nxt   = iss_q;
        mode_nxt  = mode_q;
        hold_nxt  = 1'b1;
        run_end   = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
        to_nxt    = to_q;
`endif
        case (state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_nxt = S_RST;
                    tmr_nxt   = TMR_RST;
                    cyc_nxt   = '0;
                    iss_nxt   = '0;
                    mode_nxt  = bus.step_mode;
`ifdef RUN_CTRL_WATCHDOG_EN
                    to_nxt    = 1'b0;
`endif
                end
            end
            S_RST: begin
                if (tmr == '0) begin
                    state_nxt = S_RUN;
                    // Step mode starts held until the first step pulse.
                    hold_nxt  = mode_q;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            S_RUN: begin
                if (cyc_q != CNT_MAX) cyc_nxt = cyc_q + CNT_ONE;
                if (!hold_q && (iss_q != CNT_MAX)) iss_nxt = iss_q + CNT_ONE;
                run_end = bus.mem_end;
`ifdef RUN_CTRL_WATCHDOG_EN
                if (WDOG_REACHABLE && (iss_nxt >= WDOG_LIM)) begin
                    run_end = 1'b1;
                    to_nxt  = 1'b1;
                end
`endif
                if (run_end) begin
                    state_nxt = S_DRAIN;
                    tmr_nxt   = TMR_DRAIN;
                end else begin
                    // A step seen during a release cycle is dropped, not queued.
                    hold_nxt = mode_q & ~(bus.step & hold_q);
                end
            end
            S_DRAIN: begin
                if (tmr == '0) begin
                    state_nxt = S_DUMP;
                    tmr_nxt   = TMR_DUMP;
                end else begin
                    tmr_nxt = tmr - TMR_ONE;
                end
            end
            S_DUMP: begin
                if (tmr == '0) state_nxt = S_DONE;
                else           tmr_nxt   = tmr - TMR_ONE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            tmr          <= '0;
            cyc_q        <= '0;
            iss_q        <= '0;
            mode_q       <= 1'b0;
            hold_q       <= 1'b1;
            core_reset_q <= 1'b1;
            dump_q       <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
            to_q         <= 1'b0;
`endif
        end else begin
            state        <= state_nxt;
            tmr          <= tmr_nxt;
            cyc_q        <= cyc_nxt;
            iss_q        <= iss_nxt;
            mode_q       <= mode_nxt;
            hold_q       <= hold_nxt;
            core_reset_q <= (state_nxt == S_IDLE) || (state_nxt == S_RST);
            dump_q       <= (state_nxt == S_DUMP);
            busy_q       <= (state_nxt == S_RST) || (state_nxt == S_RUN) ||
                            (state_nxt == S_DRAIN) || (state_nxt == S_DUMP);
            done_q       <= (state_nxt == S_DONE);
`ifdef RUN_CTRL_WATCHDOG_EN
            to_q         <= to_nxt;
`endif
        end
    end

    assign bus.core_reset  = core_reset_q;
    assign bus.hold        = hold_q;
    assign bus.dump_all    = dump_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.cycle_count = cyc_q;
    assign bus.issue_count = iss_q;
`ifdef RUN_CTRL_WATCHDOG_EN
    assign bus.timeout     = to_q;
`else
    assign bus.timeout     = 1'b0;
`endif

endmodule
